instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Instruction fetch stage of the MIPS CPU, directly upstream of ControlUnit/decode.
//   Holds the PC, fetches 32-bit words from instruction memory over a req/ready handshake,
//   and presents one registered instruction per slot to decode.
//   Drives if_opcode (instr[31:26]) straight into ControlUnit.Opcode.
//   Supports a decode stall and branch/jump redirect with flush.
// PARAMETERS
//   ADDR_W    32     PC / memory address width
//   RESET_PC  32'h0  PC value after reset (word aligned)
// PORTS
//   clk             in   1       clock, rising edge
//   rst_n           in   1       asynchronous active-low reset
//   imem_req        out  1       fetch request valid
//   imem_addr       out  ADDR_W  fetch address, word aligned
//   imem_ready      in   1       memory accepts request; imem_rdata valid same cycle
//   imem_rdata      in   32      fetched instruction word
//   stall           in   1       decode cannot consume if_* this cycle
//   redirect_valid  in   1       branch/jump taken; flush and refetch
//   redirect_pc     in   ADDR_W  new PC; bits [1:0] ignored (treated as 0)
//   if_valid        out  1       if_instr/if_pc hold a live instruction
//   if_instr        out  32      registered instruction word
//   if_opcode       out  6       if_instr[31:26], combinational, to ControlUnit
//   if_pc           out  ADDR_W  address of if_instr
//   if_pc_plus4     out  ADDR_W  if_pc + 4, modulo 2^ADDR_W
// BEHAVIOUR
//   - One clock, async active-low reset. During reset: pc=RESET_PC, state=FETCH,
//     if_valid=0, if_instr=0 (NOP, opcode 000000), if_pc=0, req_pc=0.
//     imem_req is gated by rst_n, so it is 0 while rst_n=0.
//   - Reset mid-transaction abandons any outstanding request; no data is kept.
//   - Slot free this cycle: slot_free = !if_valid || !stall.
//     An instruction is consumed at each rising edge where if_valid=1 and stall=0.
//   - FSM states:
//     - FETCH
//       - Outputs: imem_req=slot_free, imem_addr=pc.
//       - req and ready: capture rdata into if_instr, if_pc<=pc, if_valid<=1, pc<=pc+4.
//         Stay in FETCH, so there is one instruction per cycle at full rate.
//       - req and !ready: req_pc<=pc; go to WAIT.
//       - No req and slot consumed: if_valid<=0.
//     - WAIT
//       - Outputs: imem_req=1, imem_addr=req_pc. Request held stable until ready.
//       - The slot is always empty in WAIT.
//       - On ready: capture as in FETCH (if_pc<=req_pc, pc<=req_pc+4); go to FETCH.
//     - DRAIN
//       - Outputs: imem_req=1, imem_addr=req_pc.
//       - On ready: discard rdata; go to FETCH. pc already holds the redirect target.
//   - redirect_valid has priority over capture and stall, in every state:
//     - if_valid<=0, if_instr<=0, pc<={redirect_pc[ADDR_W-1:2],2'b00}.
//     - FETCH with req and ready: the returned word is discarded; stay in FETCH.
//     - FETCH with req and !ready: req_pc<=pc (old address); go to DRAIN.
//     - WAIT with !ready: go to DRAIN.
//     - WAIT or DRAIN with ready: discard; go to FETCH.
//     - Redirect is never lost. The first request after a redirect uses the new PC.
//   - Latency: a request accepted at edge N makes if_valid=1 after edge N.
//     Zero-wait memory gives 1 instr/cycle.
//   - pc and if_pc_plus4 wrap modulo 2^ADDR_W (0xFFFFFFFC+4 -> 0).
//   - if_instr holds its value while if_valid=1 and stall=1. No request is issued then.
// TESTING
//   1. Reset release, imem_ready=1 constant, imem returns addr-tagged words:
//      addrs 0,4,8,... each cycle; if_valid=1 from the 1st edge; if_opcode tracks instr[31:26].
//   2. Words 0x8C010000 (LW) then 0xAC010004 (SW), zero-wait:
//      if_opcode = 6'b100011 then 6'b101011 on consecutive cycles.
//   3. stall=1 for 3 cycles while if_valid=1:
//      imem_req=0, if_instr/if_pc unchanged; fetch resumes at the next pc on release.
//   4. imem_ready low for 2 cycles at addr 0x10:
//      imem_req=1 and imem_addr=0x10 stable throughout; captured on the 3rd cycle.
//   5. redirect_valid with redirect_pc=0x43 while WAIT on 0x20:
//      DRAIN keeps addr 0x20; its data is dropped; the next request is addr 0x40; if_valid=0 meanwhile.
//   6. rst_n pulsed low mid-WAIT:
//      imem_req=0 immediately; if_valid=0, if_instr=0; restart at RESET_PC.
//      Also cover pc=0xFFFFFFFC -> next fetch at 0x0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS instruction fetch stage.
// Holds the PC and fetches 32-bit words from instruction memory over a
// req/ready handshake. It presents one registered instruction per slot to
// decode, and supports a decode stall and a branch/jump redirect with flush.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_req, imem_addr                fetch request / word-aligned address
//   imem_ready, imem_rdata             memory accept + same-cycle data
//   stall                              decode cannot consume if_* this cycle
//   redirect_valid, redirect_pc        taken branch/jump target (bits [1:0] ignored)
//   if_valid, if_instr, if_pc          registered instruction slot
//   if_opcode, if_pc_plus4             decode helpers derived from the slot
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [5:0]        if_opcode,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              slot_free;
    logic              req_raw;
    logic              accept;
    logic [ADDR_W-1:0] redirect_aligned;

    // Slot can take a new word if it is empty or is being consumed this edge.
    assign slot_free        = !if_valid || !stall;
    assign req_raw          = (state == FETCH) ? slot_free : 1'b1;
    assign imem_req         = rst_n && req_raw;
    assign imem_addr        = (state == FETCH) ? pc : req_pc;
    assign accept           = req_raw && imem_ready;
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    assign if_opcode   = if_instr[INSTR_W-1 -: OP_W];
    assign if_pc_plus4 = if_pc + ADDR_W'(4);

    // State, PC and instruction-slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_pc   <= '0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (redirect_valid) begin
            // Flush the slot; any word in flight is dropped, and an
            // outstanding request is drained before the new PC is used.
            if_valid <= 1'b0;
            if_instr <= '0;
            pc       <= redirect_aligned;
            unique case (state)
                FETCH: begin
                    if (req_raw && !imem_ready) begin
                        req_pc <= pc;
                        state  <= DRAIN;
                    end
                end
                WAIT, DRAIN: state <= imem_ready ? FETCH : DRAIN;
                default:     state <= FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (accept) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + ADDR_W'(4);
                    end else begin
                        if (req_raw) begin
                            req_pc <= pc;
                            state  <= WAIT;
                        end
                        if (if_valid && !stall) begin
                            if_valid <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (imem_ready) begin
                        if_instr <= imem_rdata;
                        if_pc    <= req_pc;
                        if_valid <= 1'b1;
                        pc       <= req_pc + ADDR_W'(4);
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    // pc already holds the redirect target; the word is discarded.
                    if (imem_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with an address-tagged memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_opcode;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    logic        ovr_en;
    logic [31:0] ovr_word;

    int checks;
    int errors;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ {a[7:2], 26'h0155AA5};
    endfunction

    assign imem_rdata = ovr_en ? ovr_word : tag(imem_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string name, input logic v, input logic [31:0] pc,
                              input logic [31:0] instr);
        check({name, ".valid"}, 32'(if_valid), 32'(v));
        check({name, ".pc"}, if_pc, pc);
        check({name, ".instr"}, if_instr, instr);
    endtask

    task automatic check_req(input string name, input logic r, input logic [31:0] a);
        check({name, ".req"}, 32'(imem_req), 32'(r));
        check({name, ".addr"}, imem_addr, a);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        imem_ready     = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ovr_en         = 1'b0;
        ovr_word       = 32'h0;

        // Reset state
        #2;
        check("rst.req", 32'(imem_req), 32'h0);
        check_slot("rst", 1'b0, 32'h0, 32'h0);
        check("rst.opcode", 32'(if_opcode), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_req("t1.first", 1'b1, 32'h0);

        // 1: zero-wait streaming, one word per cycle
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            tick();
            w = tag(32'(i * 4));
            check_slot("t1", 1'b1, 32'(i * 4), w);
            check("t1.opcode", 32'(if_opcode), 32'(w[31:26]));
            check("t1.plus4", if_pc_plus4, 32'(i * 4 + 4));
            check("t1.addr", imem_addr, 32'(i * 4 + 4));
        end

        // 2: LW then SW opcodes on consecutive cycles
        ovr_en   = 1'b1;
        ovr_word = 32'h8C010000;
        tick();
        check("t2.lw", 32'(if_opcode), 32'h23);
        check("t2.lw_pc", if_pc, 32'h10);
        ovr_word = 32'hAC010004;
        tick();
        check("t2.sw", 32'(if_opcode), 32'h2B);
        check("t2.sw_pc", if_pc, 32'h14);
        ovr_en = 1'b0;

        // 3: stall holds the slot and suppresses requests
        stall = 1'b1;
        #1;
        check("t3.req0", 32'(imem_req), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_slot("t3.hold", 1'b1, 32'h14, 32'hAC010004);
            check("t3.req", 32'(imem_req), 32'h0);
        end
        stall = 1'b0;
        #1;
        check_req("t3.resume", 1'b1, 32'h18);
        tick();
        check_slot("t3.next", 1'b1, 32'h18, tag(32'h18));

        // Redirect to 0x10 with a zero-wait word in flight (word dropped)
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        check_slot("rd10", 1'b0, 32'h18, 32'h0);
        check_req("rd10", 1'b1, 32'h10);

        // 4: memory not ready for 2 cycles at 0x10
        imem_ready = 1'b0;
        #1;
        check_req("t4.c0", 1'b1, 32'h10);
        tick();
        check_req("t4.c1", 1'b1, 32'h10);
        check("t4.c1.valid", 32'(if_valid), 32'h0);
        tick();
        check_req("t4.c2", 1'b1, 32'h10);
        imem_ready = 1'b1;
        tick();
        check_slot("t4.cap", 1'b1, 32'h10, tag(32'h10));
        check_req("t4.after", 1'b1, 32'h14);

        // 5: redirect to 0x43 while waiting on 0x20
        tick();
        tick();
        tick();
        check_slot("t5.pre", 1'b1, 32'h1C, tag(32'h1C));
        imem_ready = 1'b0;
        tick();
        check("t5.wait.valid", 32'(if_valid), 32'h0);
        check_req("t5.wait", 1'b1, 32'h20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        tick();
        redirect_valid = 1'b0;
        check_req("t5.drain", 1'b1, 32'h20);
        check("t5.drain.valid", 32'(if_valid), 32'h0);
        tick();
        check_req("t5.drain2", 1'b1, 32'h20);
        imem_ready = 1'b1;
        tick();
        check("t5.dropped.valid", 32'(if_valid), 32'h0);
        check_req("t5.new", 1'b1, 32'h40);
        tick();
        check_slot("t5.cap", 1'b1, 32'h40, tag(32'h40));

        // 6: reset pulse mid-WAIT
        imem_ready = 1'b0;
        tick();
        check_req("t6.wait", 1'b1, 32'h44);
        rst_n = 1'b0;
        #1;
        check("t6.rst.req", 32'(imem_req), 32'h0);
        check_slot("t6.rst", 1'b0, 32'h0, 32'h0);
        tick();
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        #1;
        check_req("t6.restart", 1'b1, 32'h0);
        tick();
        check_slot("t6.cap", 1'b1, 32'h0, tag(32'h0));

        // PC wrap: low redirect bits ignored, 0xFFFFFFFC + 4 -> 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFE;
        tick();
        redirect_valid = 1'b0;
        check_req("wrap.req", 1'b1, 32'hFFFFFFFC);
        tick();
        check_slot("wrap.top", 1'b1, 32'hFFFFFFFC, tag(32'hFFFFFFFC));
        check("wrap.plus4", if_pc_plus4, 32'h0);
        check("wrap.addr", imem_addr, 32'h0);
        tick();
        check_slot("wrap.zero", 1'b1, 32'h0, tag(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
